// File: rtl/hsv_to_rgb_pkg.sv
// Shared Q16.16 constants, FSM state encoding and small helpers for hsv_to_rgb.
// Optional feature macro: HSV2RGB_BYTE_OUT_EN (8-bit rounded channel output).
package hsv_to_rgb_pkg;

  localparam logic [31:0] ONE        = 32'h0001_0000;  // 1.0
  localparam logic [31:0] DEG60      = 32'h003C_0000;  // 60.0 degrees
  localparam logic [31:0] RECIP60    = 32'd1092;       // 1/60 as Q16.16
  localparam logic [31:0] BYTE_SCALE = 32'd255;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SECTOR = 3'd1,
    MULT1  = 3'd2,
    MULT2  = 3'd3,
    DONE   = 3'd4
  } state_e;

  // Saturate a nominal 0..1.0 operand at exactly 1.0.
  function automatic logic [31:0] clamp_one(input logic [31:0] x);
    return (x > ONE) ? ONE : x;
  endfunction

  // Round a 0..1.0 Q16.16 value to 0..255; x never exceeds ONE, so only [7:0] can be set.
  function automatic logic [31:0] to_byte(input logic [31:0] x);
    return 32'((64'(x) * 64'(BYTE_SCALE) + 64'h8000) >> 16);
  endfunction

endpackage

// File: rtl/hsv_to_rgb_q16_mul.sv
// Combinational Q16.16 x Q16.16 -> Q16.16 multiply, truncating toward zero.
module q16_mul (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] y
);

  // Full 64-bit product, drop the 16 fractional guard bits, keep 32 bits.
  assign y = 32'((64'(a) * 64'(b)) >> 16);

endmodule

// File: rtl/hsv_to_rgb.sv
// Multi-cycle HSV -> RGB converter, Q16.16 in and out.
// Hue is reduced by repeated 60-degree subtraction, then two multiply stages.
// Define HSV2RGB_BYTE_OUT_EN to emit rounded 8-bit channels in bits [7:0].
module hsv_to_rgb
  import hsv_to_rgb_pkg::*;
(
  input  logic        Clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] H,
  input  logic [31:0] S,
  input  logic [31:0] V,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] R,
  output logic [31:0] G,
  output logic [31:0] B,
  output logic [2:0]  State
);

  state_e      state_q, state_d;
  logic [2:0]  sector_q, sector_d;
  logic [31:0] h_rem_q, h_rem_d;
  logic [31:0] s_q, s_d;
  logic [31:0] v_q, v_d;
  logic [31:0] sf_q, sf_d;
  logic [31:0] sg_q, sg_d;
  logic [31:0] r_q, r_d;
  logic [31:0] g_q, g_d;
  logic [31:0] b_q, b_d;
  logic        out_valid_q, out_valid_d;

  // Multiplier operands: 0=S*f, 1=S*(1-f), 2=p, 3=q, 4=t.
  logic [31:0] frac;
  logic [31:0] mul_a [5];
  logic [31:0] mul_b [5];
  logic [31:0] mul_y [5];

  q16_mul u_frac (.a(h_rem_q), .b(RECIP60), .y(frac));

  assign mul_a[0] = s_q;  assign mul_b[0] = frac;
  assign mul_a[1] = s_q;  assign mul_b[1] = ONE - frac;
  assign mul_a[2] = v_q;  assign mul_b[2] = ONE - s_q;
  assign mul_a[3] = v_q;  assign mul_b[3] = ONE - sf_q;
  assign mul_a[4] = v_q;  assign mul_b[4] = ONE - sg_q;

  for (genvar gi = 0; gi < 5; gi++) begin : g_mul
    q16_mul u_mul (.a(mul_a[gi]), .b(mul_b[gi]), .y(mul_y[gi]));
  end

  logic [31:0] ch_r, ch_g, ch_b;
  logic [31:0] r_fmt, g_fmt, b_fmt;

  // Route V/p/q/t onto the three channels according to the hue sector.
  always_comb begin
    ch_r = v_q;
    ch_g = mul_y[4];
    ch_b = mul_y[2];
    case (sector_q)
      3'd1:    begin ch_r = mul_y[3]; ch_g = v_q;      ch_b = mul_y[2]; end
      3'd2:    begin ch_r = mul_y[2]; ch_g = v_q;      ch_b = mul_y[4]; end
      3'd3:    begin ch_r = mul_y[2]; ch_g = mul_y[3]; ch_b = v_q;      end
      3'd4:    begin ch_r = mul_y[4]; ch_g = mul_y[2]; ch_b = v_q;      end
      3'd5:    begin ch_r = v_q;      ch_g = mul_y[2]; ch_b = mul_y[3]; end
      default: begin ch_r = v_q;      ch_g = mul_y[4]; ch_b = mul_y[2]; end
    endcase
  end

`ifdef HSV2RGB_BYTE_OUT_EN
  assign r_fmt = to_byte(ch_r);
  assign g_fmt = to_byte(ch_g);
  assign b_fmt = to_byte(ch_b);
`else
  assign r_fmt = ch_r;
  assign g_fmt = ch_g;
  assign b_fmt = ch_b;
`endif

  // Next-state and datapath update for the conversion sequence.
  always_comb begin
    state_d     = state_q;
    sector_d    = sector_q;
    h_rem_d     = h_rem_q;
    s_d         = s_q;
    v_d         = v_q;
    sf_d        = sf_q;
    sg_d        = sg_q;
    r_d         = r_q;
    g_d         = g_q;
    b_d         = b_q;
    out_valid_d = out_valid_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          h_rem_d  = H;
          s_d      = clamp_one(S);
          v_d      = clamp_one(V);
          sector_d = 3'd0;
          sf_d     = '0;
          sg_d     = '0;
          state_d  = SECTOR;
        end
      end
      SECTOR: begin
        if (h_rem_q >= DEG60) begin
          h_rem_d  = h_rem_q - DEG60;
          sector_d = (sector_q == 3'd5) ? 3'd0 : sector_q + 3'd1;
        end else begin
          state_d = MULT1;
        end
      end
      MULT1: begin
        sf_d    = mul_y[0];
        sg_d    = mul_y[1];
        state_d = MULT2;
      end
      MULT2: begin
        r_d         = r_fmt;
        g_d         = g_fmt;
        b_d         = b_fmt;
        out_valid_d = 1'b0;
        state_d     = DONE;
      end
      DONE: begin
        // out_valid rises one edge after entry; hand-off only once it is visible.
        if (out_valid_q && out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end else begin
          out_valid_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers with synchronous active-low clear.
  always_ff @(posedge Clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      sector_q    <= '0;
      h_rem_q     <= '0;
      s_q         <= '0;
      v_q         <= '0;
      sf_q        <= '0;
      sg_q        <= '0;
      r_q         <= '0;
      g_q         <= '0;
      b_q         <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sector_q    <= sector_d;
      h_rem_q     <= h_rem_d;
      s_q         <= s_d;
      v_q         <= v_d;
      sf_q        <= sf_d;
      sg_q        <= sg_d;
      r_q         <= r_d;
      g_q         <= g_d;
      b_q         <= b_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = out_valid_q;
  assign R         = r_q;
  assign G         = g_q;
  assign B         = b_q;
  assign State     = state_q;

endmodule

// File: tb/tb_hsv_to_rgb.sv
// Self-checking bench for hsv_to_rgb: directed corner cases plus random HSV
// triples checked against a real-valued HSV->RGB reference.
module tb_hsv_to_rgb;

  localparam logic [31:0] Q_ONE = 32'h0001_0000;
`ifdef HSV2RGB_BYTE_OUT_EN
  localparam int  DEF_TOL = 1;
  localparam real OUT_SCALE = 255.0;
`else
  localparam int  DEF_TOL = 64;
  localparam real OUT_SCALE = 65536.0;
`endif

  logic        Clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] H, S, V;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] R, G, B;
  logic [2:0]  State;

  int total = 0;
  int bad   = 0;

  hsv_to_rgb dut (
    .Clk(Clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .H(H), .S(S), .V(V), .out_valid(out_valid), .out_ready(out_ready),
    .R(R), .G(G), .B(B), .State(State)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_tol(input string tag, input logic [31:0] obs, input logic [31:0] exp,
                         input int tol);
    longint diff;
    logic   ok;
    diff = longint'(obs) - longint'(exp);
    if (diff < 0) diff = -diff;
    ok = (^obs !== 1'bx) && (diff <= longint'(tol));
    total++;
    assert (ok === 1'b1) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h tol=%0d", tag, obs, exp, tol);
    end
  endtask

  // Textbook HSV->RGB in real arithmetic, then scaled to the output format.
  task automatic model(input logic [31:0] h, input logic [31:0] s, input logic [31:0] v,
                       output logic [31:0] er, output logic [31:0] eg, output logic [31:0] eb);
    real hd, sd, vd, f, p, q, t, rr, gg, bb;
    int  sec;
    hd = real'(h) / 65536.0;
    hd = hd - 360.0 * $floor(hd / 360.0);
    sd = real'(s) / 65536.0;  if (sd > 1.0) sd = 1.0;
    vd = real'(v) / 65536.0;  if (vd > 1.0) vd = 1.0;
    sec = $rtoi($floor(hd / 60.0));
    f = hd / 60.0 - real'(sec);
    p = vd * (1.0 - sd);
    q = vd * (1.0 - sd * f);
    t = vd * (1.0 - sd * (1.0 - f));
    case (sec)
      0:       begin rr = vd; gg = t;  bb = p;  end
      1:       begin rr = q;  gg = vd; bb = p;  end
      2:       begin rr = p;  gg = vd; bb = t;  end
      3:       begin rr = p;  gg = q;  bb = vd; end
      4:       begin rr = t;  gg = p;  bb = vd; end
      default: begin rr = vd; gg = p;  bb = q;  end
    endcase
    er = 32'($rtoi(rr * OUT_SCALE + 0.5));
    eg = 32'($rtoi(gg * OUT_SCALE + 0.5));
    eb = 32'($rtoi(bb * OUT_SCALE + 0.5));
  endtask

  // One full handshake: accept, latency, result, DONE hold with ignored pulses, pop.
  task automatic run_txn(input string name, input logic [31:0] h, input logic [31:0] s,
                         input logic [31:0] v, input int tol, input int hold);
    logic [31:0] er, eg, eb;
    int lat, n;
    model(h, s, v, er, eg, eb);
    n = int'(h / 32'h003C_0000);
    chk({name, "_in_ready"}, {31'd0, in_ready}, 32'd1);
    H = h; S = s; V = v; in_valid = 1'b1;
    @(posedge Clk); #1;
    in_valid = 1'b0;
    H = $urandom; S = $urandom; V = $urandom;
    lat = 0;
    while (out_valid !== 1'b1 && lat < 2000) begin
      @(posedge Clk); #1;
      lat++;
    end
    chk({name, "_latency"}, 32'(lat), 32'(n + 4));
    chk_tol({name, "_R"}, R, er, tol);
    chk_tol({name, "_G"}, G, eg, tol);
    chk_tol({name, "_B"}, B, eb, tol);
    for (int i = 0; i < hold; i++) begin
      in_valid = (i % 2 == 0);
      H = $urandom;
      @(posedge Clk); #1;
      chk({name, "_hold_valid"}, {31'd0, out_valid}, 32'd1);
      chk({name, "_hold_in_ready"}, {31'd0, in_ready}, 32'd0);
      chk_tol({name, "_hold_R"}, R, er, tol);
      chk_tol({name, "_hold_G"}, G, eg, tol);
      chk_tol({name, "_hold_B"}, B, eb, tol);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge Clk); #1;
    out_ready = 1'b0;
    chk({name, "_pop_valid"}, {31'd0, out_valid}, 32'd0);
    chk({name, "_pop_state"}, {29'd0, State}, 32'd0);
    chk_tol({name, "_retain_R"}, R, er, tol);
    $display("txn %s H=%h S=%h V=%h lat=%0d R=%h G=%h B=%h exp=%h/%h/%h",
             name, h, s, v, lat, R, G, B, er, eg, eb);
  endtask

  initial begin
    reset = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    H = '0; S = '0; V = '0;
    repeat (2) @(posedge Clk);
    #1;
    reset = 1'b1;
    chk("rst_in_ready",  {31'd0, in_ready},  32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_state",     {29'd0, State},     32'd0);
    chk("rst_R", R, 32'd0);
    chk("rst_G", G, 32'd0);
    chk("rst_B", B, 32'd0);

    // Red primary, with a long DONE hold and ignored in_valid pulses.
    run_txn("h0_red", 32'h0000_0000, Q_ONE, Q_ONE, 0, 3);

    // Reset while still in SECTOR must clear everything.
    H = 32'h0FFF_0000; S = Q_ONE; V = Q_ONE; in_valid = 1'b1;
    @(posedge Clk); #1;
    in_valid = 1'b0;
    repeat (2) begin @(posedge Clk); #1; end
    chk("mid_state_sector", {29'd0, State}, 32'd1);
    reset = 1'b0;
    @(posedge Clk); #1;
    reset = 1'b1;
    chk("mid_rst_state",     {29'd0, State},     32'd0);
    chk("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_rst_in_ready",  {31'd0, in_ready},  32'd1);
    chk("mid_rst_R", R, 32'd0);
    chk("mid_rst_G", G, 32'd0);
    chk("mid_rst_B", B, 32'd0);

    run_txn("h120_green", 32'h0078_0000, Q_ONE, Q_ONE, 0, 0);
    run_txn("h200_grey",  32'h00C8_0000, 32'd0, 32'h0000_8000, 0, 1);
    run_txn("h400_wrap",  32'h0190_0000, Q_ONE, Q_ONE, DEF_TOL, 0);
    run_txn("hmax_s0_vclamp", 32'hFFFF_0000, 32'd0, 32'h0002_0000, 0, 0);

    for (int k = 0; k < 25; k++) begin
      run_txn($sformatf("rnd%0d", k), 32'($urandom_range(0, 32'h0FFF_FFFF)),
              32'($urandom_range(0, 32'h0001_4000)), 32'($urandom_range(0, 32'h0001_4000)),
              DEF_TOL, int'($urandom_range(0, 2)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hsv_to_rgb.md
HSV_TO_RGB -- requirements
Module: hsv_to_rgb

Interface
REQ-001 Clk  input  1  single clock; all state changes on rising edge.
REQ-002 reset  input  1  synchronous, active-low reset; sampled on Clk rising edge.
REQ-003 in_valid  input  1  H/S/V present this cycle.
REQ-004 in_ready  output  1  block can accept; combinational, equal to (State==IDLE).
REQ-005 H  input  32  hue, unsigned Q16.16 degrees, any value (wrapped mod 360.0).
REQ-006 S  input  32  saturation, unsigned Q16.16, nominal 0..1.0.
REQ-007 V  input  32  value, unsigned Q16.16, nominal 0..1.0.
REQ-008 out_valid  output  1  R/G/B valid; registered.
REQ-009 out_ready  input  1  consumer takes result this cycle.
REQ-010 R, G, B  output  32 each  result channels; registered.
REQ-011 State  output  3  current FSM state, debug observation.

Function
REQ-012 The block SHALL capture H,S,V on an edge where in_valid=1 and in_ready=1; S and V above 0x00010000 SHALL be clamped to 0x00010000 at capture.
REQ-013 FSM SHALL have states IDLE=0, SECTOR=1, MULT1=2, MULT2=3, DONE=4; codes 5-7 SHALL return to IDLE on the next edge.
REQ-014 IDLE -> SECTOR on accept.
REQ-015 SECTOR: each cycle, if h_rem >= 60.0 (0x003C0000), subtract 60.0 and increment sector; sector 5->0 wrap on increment (mod 360); otherwise go to MULT1.
REQ-016 MULT1: f = (h_rem*1092)>>16 (Q16.16 fraction, 1092 = 1/60), register sf = S*f and sg = S*(ONE-f), Q16.16 multiplies truncated.
REQ-017 MULT2: p = V*(ONE-S), q = V*(ONE-sf), t = V*(ONE-sg), truncated; go to DONE.
REQ-018 On entry to DONE: R,G,B loaded per sector 0:(V,t,p) 1:(q,V,p) 2:(p,V,t) 3:(p,q,V) 4:(t,p,V) 5:(V,p,q); out_valid=1.
REQ-019 Latency: with n = number of 60.0 subtractions, out_valid SHALL rise on the (n+4)th rising edge after the accepting edge.
REQ-020 DONE: R,G,B,out_valid SHALL hold stable while out_ready=0; on out_ready=1 go to IDLE with out_valid=0, R/G/B retaining their last values.
REQ-021 No new input SHALL be accepted outside IDLE; in_valid ignored there.
REQ-022 S=0 SHALL yield R=G=B=V (exact) regardless of H.
REQ-023 Accuracy: each channel within ±64 LSB of ideal Q16.16 result.

Reset
REQ-024 reset=0 at an edge SHALL force State=IDLE, R=G=B=0, out_valid=0, and clear sector/h_rem/intermediates, from any state including mid-SECTOR or DONE.
REQ-025 in_ready SHALL read 1 on the first cycle after reset is released.

Configuration
REQ-026 Macro HSV2RGB_BYTE_OUT_EN: when defined, each channel SHALL output (x*255 + 0x8000)>>16 in bits [7:0], bits [31:8]=0 (1.0 -> 255); latency unchanged.
REQ-027 When undefined, channels SHALL be Q16.16 as in REQ-018.

Structure
REQ-028 Shared package holds Q16.16 constants ONE=0x00010000, DEG60=0x003C0000, RECIP60=1092, BYTE_SCALE=255, and the state encodings.
REQ-029 One sub-module q16_mul (32x32 -> 32 Q16.16, truncating, combinational) SHALL be instantiated for all products.

Verification
REQ-030 H=0, S=1.0, V=1.0 -> R=0x00010000, G=0, B=0; out_valid 4 edges after accept.
REQ-031 H=120.0 (0x00780000), S=V=1.0 -> R=0, G=0x00010000, B=0; out_valid 6 edges after accept.
REQ-032 H=200.0, S=0, V=0x00008000 -> R=G=B=0x00008000.
REQ-033 H=400.0, S=V=1.0 -> wraps to sector 0: R=0x00010000, G=0x0000AAA0 ±64, B=0; out_valid 10 edges after accept.
REQ-034 reset=0 for one edge during SECTOR -> next cycle State=0, out_valid=0, in_ready=1, R=G=B=0.
REQ-035 out_ready held 0 for 3 cycles in DONE -> outputs stable, in_ready=0, in_valid pulses ignored; out_ready=1 -> IDLE next edge. With HSV2RGB_BYTE_OUT_EN, REQ-030 yields R=0x000000FF.
